word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-in, serial-out unloader for 32-bit datapath words: accepts one word over a valid/ready handshake and drains it one bit per accepted beat on a serial valid/ready output, LSB first. It is the read-side counterpart to the team's parallel-load register: the register captures a full word in one edge, and this block reads a full word out bit by bit toward narrow links such as the debug/scan port and the bit-serial test channel.

## Interface
- `WIDTH`, default 32: data word width in bits; legal range is 2..64.
- `clk`  input  1: clock, positive-edge.
- `reset`  input  1: reset, synchronous, active-high; sampled on the rising edge of `clk`.
- `in_data`  input  WIDTH: word to serialize; sampled on the input handshake.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: block can accept a word.
- `out_bit`  output  1: current serial bit.
- `out_valid`  output  1: `out_bit` is valid.
- `out_ready`  input  1: the sink accepts `out_bit` this cycle.
- `out_last`  output  1: the current bit is the final bit of the frame.
- `busy`  output  1: a frame is in progress.

## Operation
- Two-state FSM: IDLE and SHIFT. Internal state is a WIDTH-bit shift register `sr` and a bit counter `cnt` of width clog2(WIDTH+2).
- IDLE:
  - `in_ready`=1, and `in_ready` is also held low in any cycle where `reset`=1.
  - On `in_valid && in_ready`: `sr` <= `in_data`, `cnt` <= 0, and the FSM moves to SHIFT.
- SHIFT:
  - `out_valid`=1 and `out_bit`=`sr[0]`.
  - On `out_valid && out_ready`: `sr` shifts right by 1, `cnt` increments, and the bit is consumed.
  - `out_last`=1 when `cnt`==FRAME-1, where FRAME=WIDTH, or WIDTH+1 with parity (see Configuration).
  - When the `out_last` beat is accepted, the FSM returns to IDLE.
- If `out_ready`=0, all outputs and state hold. `out_bit` must not change while `out_valid`=1 and the beat has not been accepted.
- `busy` is 1 exactly when the FSM is in SHIFT. `in_ready` is the logical inverse of `busy`, except during reset.
- `in_valid` is ignored while in SHIFT. No word is lost, because `in_ready`=0 during SHIFT.
- Reset values: FSM=IDLE, `sr`=0, `cnt`=0, `out_valid`=0, `out_bit`=0, `out_last`=0, `busy`=0.
- Reset asserted mid-frame aborts the frame on that edge. The remaining bits are discarded, and the cycle after reset deasserts shows `in_ready`=1.
- Reset takes priority over every handshake in the same cycle.

## Timing
- Load latency: a word accepted at edge N puts its bit 0 on `out_bit` with `out_valid`=1 after edge N.
- With `out_ready` held at 1, bit k appears after edge N+k.
- The final beat is accepted at edge N+FRAME. `in_ready` is 1 in the following cycle, so there is one idle bubble between frames.
- Sustained throughput is one word per FRAME+1 cycles.
- All outputs are registered or decoded from registered state only. There are no combinational paths from input to output.

## Configuration
- Macro: `WORD_SERIALIZER_PARITY_EN`.
- Defined:
  - An even-parity bit is appended after the data bit WIDTH-1, giving FRAME=WIDTH+1.
  - The parity bit is the XOR of all `in_data` bits, captured on load into a separate flop.
  - `out_last` is asserted on the parity beat only.
- Undefined:
  - No parity flop exists and FRAME=WIDTH.
  - `out_last` is asserted on data bit WIDTH-1.

## Test plan
- **Reset then single word.** Assert reset for 2 cycles, then load 0x0000_0005 with `out_ready`=1.
  - Required `out_bit` sequence: 1,0,1 then 29 zeros.
  - `out_last` is high only on beat 31 (or on beat 32 = parity 0 when the macro is defined).
  - `in_ready` returns to 1 one cycle after the last beat.
- **Backpressure.** Load 0x8000_0001, then toggle `out_ready` 1,0,0,1,...
  - `out_bit` holds its value across the stalled cycles.
  - All 32 bits are delivered in order, with bit 31=1 last.
  - Total beats equal FRAME.
- **Input ignored while busy.** Hold `in_valid`=1 with changing `in_data` throughout a frame of 0xFFFF_FFFF.
  - `in_ready` stays 0 for the whole frame.
  - The output is 32 ones, plus parity 0 when the macro is defined.
  - The second word is accepted only after the frame completes.
- **Reset mid-frame.** Assert reset after beat 10 of 0xA5A5_A5A5.
  - Next cycle: `out_valid`=0, `busy`=0, `out_last`=0.
  - After reset deasserts, `in_ready`=1 and a new word 0x1 serializes correctly from bit 0.
- **Parity (macro defined).** Load 0x0000_0007.
  - Beat 32 carries `out_bit`=1 with `out_last`=1.
  - With 0x0000_0003, the parity beat is 0.
- **Back-to-back.** Keep `in_valid` continuously high with words 0x1, 0x2 and `out_ready`=1.
  - The second word is accepted exactly FRAME+1 cycles after the first.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-in, serial-out unloader: one WIDTH-bit word in, one bit per accepted beat out, LSB first.
// Stalls hold all state; optional even-parity trailer bit under WORD_SERIALIZER_PARITY_EN.
module word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_accept;
  logic             at_last;

`ifdef WORD_SERIALIZER_PARITY_EN
  logic par_q, par_d;
`endif

  assign at_last   = (cnt_q == LAST_CNT);
  assign in_accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef WORD_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_accept) begin
          sr_d    = in_data;
          cnt_d   = '0;
`ifdef WORD_SERIALIZER_PARITY_EN
          par_d   = ^in_data;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (at_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
`ifdef WORD_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // All outputs decode registered state; reset gating of in_ready is the one exception.
  assign busy      = (state_q == SHIFT);
  assign out_valid = busy;
  assign out_last  = busy && at_last;
  assign in_ready  = !busy && !reset;
`ifdef WORD_SERIALIZER_PARITY_EN
  assign out_bit   = busy && (at_last ? par_q : sr_q[0]);
`else
  assign out_bit   = busy && sr_q[0];
`endif

  a_stall_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_bit)));

  a_ready_busy: assert property (@(posedge clk) disable iff (reset)
    (in_ready != busy));

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: bit-queue reference model checked every cycle, plus literal frame checks.
module tb_word_serializer;
  localparam int WIDTH = 32;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int PAR = FRAME - WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit exp_q[$];
  bit beats[$];
  bit lasts[$];
  int acc_cyc[$];

  word_serializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just its list of bits; the queue front is the bit on the wire.
  always @(negedge clk) begin
    cyc_n++;
    check("busy", busy, exp_q.size() != 0);
    check("out_valid", out_valid, exp_q.size() != 0);
    check("in_ready", in_ready, (exp_q.size() == 0) && !reset);
    if (exp_q.size() != 0) begin
      check("out_bit", out_bit, exp_q[0]);
      check("out_last", out_last, exp_q.size() == 1);
    end else begin
      check("out_last_idle", out_last, 1'b0);
    end
    if (!reset && out_valid && out_ready) begin
      beats.push_back(out_bit);
      lasts.push_back(out_last);
    end
    if (!reset && in_valid && in_ready) acc_cyc.push_back(cyc_n);
    if (reset) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (out_ready) void'(exp_q.pop_front());
    end else if (in_valid) begin
      for (int i = 0; i < WIDTH; i++) exp_q.push_back(in_data[i]);
      if (PAR == 1) exp_q.push_back(^in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    beats.delete();
    lasts.delete();
    acc_cyc.delete();
  endtask

  task automatic load(input logic [WIDTH-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (busy === 1'b1 && k < maxc) begin
      tick();
      k++;
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  function automatic logic bt(input int i);
    return (i < beats.size()) ? beats[i] : 1'bx;
  endfunction

  function automatic logic lt(input int i);
    return (i < lasts.size()) ? lasts[i] : 1'bx;
  endfunction

  function automatic int ones(input int from, input int n);
    int s;
    s = 0;
    for (int i = from; i < from + n && i < beats.size(); i++) s += beats[i];
    return s;
  endfunction

  function automatic int last_count();
    int s;
    s = 0;
    foreach (lasts[i]) s += lasts[i];
    return s;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [10:0] obs;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    reset = 1'b0;

    // Single word 0x5
    clear_logs();
    out_ready = 1'b1;
    load(32'h0000_0005);
    wait_idle(100);
    check("t1_len", beats.size(), FRAME);
    check("t1_b0", bt(0), 1'b1);
    check("t1_b1", bt(1), 1'b0);
    check("t1_b2", bt(2), 1'b1);
    check("t1_ones", ones(0, FRAME), 2);
    check("t1_last_cnt", last_count(), 1);
    check("t1_last_pos", lt(FRAME-1), 1'b1);
    check("t1_in_ready", in_ready, 1'b1);

    // Backpressure with ready pattern 1,0,0,1
    clear_logs();
    load(32'h8000_0001);
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
      k++;
    end
    out_ready = 1'b1;
    check("t2_len", beats.size(), FRAME);
    check("t2_b0", bt(0), 1'b1);
    check("t2_b31", bt(31), 1'b1);
    check("t2_ones", ones(0, FRAME), 2);
    check("t2_last_pos", lt(FRAME-1), 1'b1);

    // in_valid held with changing data while busy
    clear_logs();
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    tick();
    k = 0;
    while (busy === 1'b1 && k < 100) begin
      check("t3_in_ready_busy", in_ready, 1'b0);
      in_data = $urandom;
      tick();
      k++;
    end
    check("t3_acc_during", acc_cyc.size(), 1);
    in_data = 32'h0000_0003;
    tick();
    in_valid = 1'b0;
    check("t3_acc_after", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("t3_gap", acc_cyc[1] - acc_cyc[0], FRAME + 1);
    wait_idle(100);
    check("t3_ones_first", ones(0, WIDTH), WIDTH);
    if (PAR == 1) check("t3_parity", bt(WIDTH), 1'b0);
    check("t3_len", beats.size(), 2 * FRAME);
    check("t3_second_b0", bt(FRAME), 1'b1);
    check("t3_second_b1", bt(FRAME + 1), 1'b1);
    check("t3_second_ones", ones(FRAME, FRAME), 2);

    // Reset mid-frame after beat 10
    clear_logs();
    load(32'hA5A5_A5A5);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    check("t4_out_valid", out_valid, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_out_last", out_last, 1'b0);
    check("t4_in_ready_rst", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("t4_in_ready", in_ready, 1'b1);
    check("t4_beats", beats.size(), 11);
    for (int i = 0; i < 11; i++) obs[i] = bt(i);
    check("t4_bits", obs, {3'b101, 8'hA5});
    clear_logs();
    load(32'h0000_0001);
    wait_idle(100);
    check("t4_new_len", beats.size(), FRAME);
    check("t4_new_b0", bt(0), 1'b1);
    check("t4_new_ones", ones(0, FRAME), 1 + PAR);

    // Last beat of 0x7 and 0x3: parity bit when enabled, data bit 31 otherwise
    clear_logs();
    load(32'h0000_0007);
    wait_idle(100);
    check("t5_last_bit7", bt(FRAME-1), (PAR == 1) ? 1'b1 : 1'b0);
    check("t5_last_flag7", lt(FRAME-1), 1'b1);
    check("t5_ones7", ones(0, FRAME), 3 + PAR);
    clear_logs();
    load(32'h0000_0003);
    wait_idle(100);
    check("t5_last_bit3", bt(FRAME-1), 1'b0);
    check("t5_last_flag3", lt(FRAME-1), 1'b1);

    // Back-to-back words 0x1, 0x2
    clear_logs();
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    tick();
    in_data = 32'h0000_0002;
    k = 0;
    while (acc_cyc.size() < 2 && k < 100) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("t6_acc", acc_cyc.size(), 2);
    if (acc_cyc.size() == 2) check("t6_gap", acc_cyc[1] - acc_cyc[0], FRAME + 1);
    wait_idle(100);
    check("t6_len", beats.size(), 2 * FRAME);
    check("t6_w1_b0", bt(0), 1'b1);
    check("t6_w2_b0", bt(FRAME), 1'b0);
    check("t6_w2_b1", bt(FRAME + 1), 1'b1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
